// File: rtl/conv_layer_ctrl.sv
// Control FSM for a convolution layer: loads NUM_FIL KERxKER filters, then raster-walks a
// KERxKER window over an IMG_HxIMG_W image, producing addresses, indices and write enables.
module conv_layer_ctrl #(
  parameter int IMG_W   = 16,
  parameter int IMG_H   = 16,
  parameter int KER     = 4,
  parameter int NUM_FIL = 4,
  parameter int STRIDE  = 1,
  parameter int IDX_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ldBuf,
  output logic [IDX_W-1:0]   memIdx,
  output logic               baseSel,
  output logic [IDX_W-1:0]   idxI,
  output logic [IDX_W-1:0]   idxJ,
  output logic [NUM_FIL-1:0] filWrEn,
  output logic               bufWrEn,
  output logic [IDX_W-1:0]   winRow,
  output logic [IDX_W-1:0]   winCol,
  output logic               ldDone,
  output logic               done
);

  localparam int KK    = KER * KER;
  localparam int OUT_W = (IMG_W - KER) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - KER) / STRIDE + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_FILTER,
    S_LOAD_BUFFER,
    S_UPDATE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] fil_cnt, row_cnt, col_cnt;
  logic             fil_last, row_last, col_last, win_last;

  assign fil_last = (fil_cnt == IDX_W'(NUM_FIL * KK - 1));
  assign row_last = (row_cnt == IDX_W'(KER - 1));
  assign col_last = (col_cnt == IDX_W'(KER - 1));
  assign win_last = (winRow == IDX_W'(OUT_H - 1)) && (winCol == IDX_W'(OUT_W - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    memIdx  = '0;
    baseSel = 1'b0;
    idxI    = '0;
    idxJ    = '0;
    filWrEn = '0;
    bufWrEn = 1'b0;
    ldDone  = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD_FILTER;
      S_LOAD_FILTER: begin
        memIdx  = fil_cnt;
        filWrEn = NUM_FIL'(1) << (fil_cnt / IDX_W'(KK));
        idxI    = (fil_cnt % IDX_W'(KK)) / IDX_W'(KER);
        idxJ    = fil_cnt % IDX_W'(KER);
        if (fil_last) state_d = S_LOAD_BUFFER;
      end
      S_LOAD_BUFFER: begin
        bufWrEn = 1'b1;
        baseSel = 1'b1;
        idxI    = row_cnt;
        idxJ    = col_cnt;
        memIdx  = (winRow * IDX_W'(STRIDE) + row_cnt) * IDX_W'(IMG_W)
                + winCol * IDX_W'(STRIDE) + col_cnt;
        if (row_last && col_last) state_d = S_UPDATE;
      end
      S_UPDATE: state_d = win_last ? S_DONE : S_WAIT;
      S_WAIT: begin
        ldDone = 1'b1;
        if (ldBuf) state_d = S_LOAD_BUFFER;
      end
      S_DONE: begin
        ldDone = 1'b1;
        done   = 1'b1;
        if (start) state_d = S_LOAD_FILTER;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fil_cnt <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      winRow  <= '0;
      winCol  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            fil_cnt <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
            winRow  <= '0;
            winCol  <= '0;
          end
        end
        S_LOAD_FILTER: fil_cnt <= fil_last ? '0 : fil_cnt + 1'b1;
        S_LOAD_BUFFER: begin
          if (col_last) begin
            col_cnt <= '0;
            row_cnt <= row_last ? '0 : row_cnt + 1'b1;
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end
        S_UPDATE: begin
          // The final window stays visible in DONE.
          if (!win_last) begin
            if (winCol == IDX_W'(OUT_W - 1)) begin
              winCol <= '0;
              winRow <= winRow + 1'b1;
            end else begin
              winCol <= winCol + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
